ctlab_token_tx: RTL and testbench
=================================

// Module: ctlab_token_tx
// PURPOSE
//  Control-token transmitter: the driving end of the 4-wire code bus {a,b,c,d} that the
//  CT1/CT2 token decoder watches. Accepts token requests over a valid/ready handshake and
//  drives CT1 (a'.b.c.d' = 4'b0110) or CT2 (a.b'.c.d = 4'b1011) for HOLD_CYCLES clocks.
//  Between tokens it drives IDLE_CODE for GAP_CYCLES clocks. One request can be pending.
// PARAMETERS
//  HOLD_CYCLES  10       clocks each token is held on the bus; legal range >= 1
//  GAP_CYCLES   1        clocks of IDLE_CODE after each token; 0 means no gap
//  IDLE_CODE    4'b0000  bus value when no token is driven; must match neither CT1 nor CT2
// PORTS
//  clk        in   1  rising-edge clock
//  rst_n      in   1  asynchronous active-low reset
//  req_valid  in   1  token request valid
//  req_sel    in   1  0 = CT1 (0110), 1 = CT2 (1011); sampled on accept
//  req_ready  out  1  request can be accepted; equals !pend_valid
//  a,b,c,d    out  1  code bus bits, a = MSB; all registered
//  tx_busy    out  1  high whenever the FSM is not in IDLE
//  tx_done    out  1  one-cycle pulse on the last DRIVE cycle of each token
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - {a,b,c,d} = IDLE_CODE; tx_busy = 0; tx_done = 0
//   - pend_valid = 0, so req_ready = 1; FSM = IDLE
//  Accept: a request is accepted on any rising edge with req_valid && req_ready.
//  FSM states: IDLE, DRIVE, GAP. The hold/gap counter is $clog2(max(HOLD,GAP)+1) bits wide.
//  Launch point: IDLE, last GAP cycle, or last DRIVE cycle when GAP_CYCLES = 0.
//   - At the launch point, the next token is pending if pend_valid, else this cycle's
//     accepted request.
//   - If a token is taken, go to DRIVE and load the counter. Otherwise go to / stay in IDLE.
//   - Requests accepted outside a launch point go to the pending register.
//  Conflict freedom: req_ready = !pend_valid, so a new accept and a pending pop never coincide.
//  Latency: request accepted in IDLE at edge N -> code on bus from cycle N+1 through N+HOLD_CYCLES.
//  DRIVE: bus = token code for exactly HOLD_CYCLES cycles; tx_done = 1 in the final one.
//   - Next state is GAP, or the launch decision if GAP_CYCLES = 0.
//  GAP: bus = IDLE_CODE for exactly GAP_CYCLES cycles.
//  Back-to-back with GAP_CYCLES = 0: the bus changes code to code with no IDLE_CODE cycle.
//   - tx_busy stays high throughout.
//  Pending full: req_ready = 0 and req_valid/req_sel are ignored.
//   - The requester must hold its request. Nothing is dropped or overwritten.
//  Reset mid-operation: the bus returns to IDLE_CODE immediately and the pending token is
//   discarded. No tx_done pulse is issued for the aborted token.
//  The bus never shows a value other than CT1, CT2 or IDLE_CODE (no glitch codes).
// TESTING (HOLD_CYCLES = 10, GAP_CYCLES = 1 unless noted; decoder instance on bus as checker)
//  1. Single CT1 accepted at edge 0:
//     -> abcd = 0110 cycles 1-10; tx_done at cycle 10; 0000 at cycle 11
//     -> tx_busy 1 for cycles 1-11; decoder out1 high for exactly 10 cycles
//  2. CT1 at edge 0, then CT2 at edge 1:
//     -> CT2 is pended; req_ready = 0 for cycles 2-11
//     -> abcd = 1011 for cycles 12-21; gap 0000 at cycles 11 and 22
//  3. Third request held valid while pending is full:
//     -> not accepted until req_ready rises at cycle 12
//     -> drives cycles 23-32; request count in = token count out
//  4. GAP_CYCLES = 0, CT2 then CT1 back-to-back:
//     -> 1011 cycles 1-10, 0110 cycles 11-20, tx_busy continuously 1, two tx_done pulses
//  5. rst_n low at cycle 5 with CT2 pending:
//     -> abcd = 0000 asynchronously; tx_busy = 0; req_ready = 1
//     -> after release no token appears without a new request
//  6. Random valid/req_sel stream, 1000 requests:
//     -> every decoded token matches req_sel in order
//     -> each token's high time = HOLD_CYCLES; no non-token/non-idle bus value ever

Source files
------------

// File: rtl/ctlab_token_tx.sv
// ctlab_token_tx: control-token transmitter driving CT1/CT2 codes onto the {a,b,c,d} bus
//   clk, rst_n            clock, async active-low reset
//   req_valid, req_sel    token request (sel 0 = CT1 0110, 1 = CT2 1011), req_ready = !pend_valid
//   a,b,c,d               registered code bus, a = MSB
//   tx_busy, tx_done      FSM not idle; pulse on last hold cycle of each token
module ctlab_token_tx #(
  parameter int HOLD_CYCLES = 10,
  parameter int GAP_CYCLES = 1,
  parameter logic [3:0] IDLE_CODE = 4'b0000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_valid,
  input  logic req_sel,
  output logic req_ready,
  output logic a,
  output logic b,
  output logic c,
  output logic d,
  output logic tx_busy,
  output logic tx_done
);
  localparam int MX = HOLD_CYCLES > GAP_CYCLES ? HOLD_CYCLES : GAP_CYCLES;
  localparam int W = $clog2(MX + 1);
  localparam logic [3:0] CT1 = 4'b0110;
  localparam logic [3:0] CT2 = 4'b1011;
  typedef enum logic [1:0] {IDLE, DRIVE, GAP} state_t;
  state_t state, state_n;
  logic [W-1:0] cnt, cnt_n;
  logic [3:0] bus, bus_n;
  logic pend_valid, pend_valid_n, pend_sel, pend_sel_n, cur_sel, cur_sel_n;
  logic accept, last, launch, take, done_n;
  assign req_ready = !pend_valid;
  assign {a, b, c, d} = bus;
  assign tx_busy = state != IDLE;
  // cnt holds the cycles remaining in the current DRIVE/GAP phase, including this one
  always_comb begin
    accept = req_valid && req_ready;
    last = cnt == W'(1);
    launch = state == IDLE || (state == GAP && last) || (state == DRIVE && last && GAP_CYCLES == 0);
    take = launch && (pend_valid || accept);
    state_n = state;
    cnt_n = cnt;
    cur_sel_n = cur_sel;
    pend_valid_n = pend_valid;
    pend_sel_n = pend_sel;
    if (take) begin
      state_n = DRIVE;
      cnt_n = W'(HOLD_CYCLES);
      cur_sel_n = pend_valid ? pend_sel : req_sel;
      pend_valid_n = 1'b0;
    end else if (launch) begin
      state_n = IDLE;
    end else if (!last) begin
      cnt_n = cnt - W'(1);
    end else begin
      state_n = GAP;
      cnt_n = W'(GAP_CYCLES);
    end
    // ready is low while pending is full, so an accept here never collides with a pop
    if (accept && !take) begin
      pend_valid_n = 1'b1;
      pend_sel_n = req_sel;
    end
    bus_n = state_n == DRIVE ? (cur_sel_n ? CT2 : CT1) : IDLE_CODE;
    done_n = state_n == DRIVE && cnt_n == W'(1);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      bus <= IDLE_CODE;
      pend_valid <= 1'b0;
      pend_sel <= 1'b0;
      cur_sel <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      bus <= bus_n;
      pend_valid <= pend_valid_n;
      pend_sel <= pend_sel_n;
      cur_sel <= cur_sel_n;
      tx_done <= done_n;
    end
  end
endmodule

// File: tb/tb_ctlab_token_tx.sv
// tb_ctlab_token_tx: self-checking bench for ctlab_token_tx (gap 1 and gap 0 instances)
module tb_ctlab_token_tx;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_valid = 1'b0, req_sel = 1'b0, req_ready, a, b, c, d, tx_busy, tx_done;
  logic req0_valid = 1'b0, req0_sel = 1'b0, req0_ready, a0, b0, c0, d0, busy0, done0;
  int tests = 0;
  int fails = 0;
  typedef struct {
    logic v;
    logic s;
    logic [3:0] abcd;
    logic busy;
    logic done;
    logic ready;
  } vec_t;
  vec_t tbl[24];
  logic [3:0] log_bus[64];
  logic log_busy[64];
  logic log_done[64];
  logic [3:0] q[$];
  logic mon_en = 1'b0;
  int run = 0;
  int tokens = 0;
  logic [3:0] run_code = 4'h0;
  logic [3:0] mv;
  logic [3:0] ex;
  ctlab_token_tx #(.HOLD_CYCLES(10), .GAP_CYCLES(1), .IDLE_CODE(4'b0000)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_sel(req_sel), .req_ready(req_ready),
    .a(a), .b(b), .c(c), .d(d), .tx_busy(tx_busy), .tx_done(tx_done)
  );
  ctlab_token_tx #(.HOLD_CYCLES(10), .GAP_CYCLES(0), .IDLE_CODE(4'b0000)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req0_valid), .req_sel(req0_sel), .req_ready(req0_ready),
    .a(a0), .b(b0), .c(c0), .d(d0), .tx_busy(busy0), .tx_done(done0)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic do_reset();
    req_valid = 1'b0;
    req0_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask
  // reference monitor: each run of token code must last HOLD cycles and match the next accepted request
  always @(negedge clk) begin
    if (mon_en) begin
      mv = {a, b, c, d};
      if (!(mv == 4'h0 || mv == 4'h6 || mv == 4'hb)) check("bus legal", 32'(mv), 32'h0);
      if (mv != 4'h0) begin
        if (run == 0) run_code = mv;
        else if (mv != run_code) check("code change in run", 32'(mv), 32'(run_code));
        run++;
      end else if (run > 0) begin
        if (q.size() == 0) check("token without request", 32'(q.size()), 32'd1);
        else begin
          ex = q.pop_front();
          check("token code", 32'(run_code), 32'(ex));
        end
        check("token length", run, 10);
        tokens++;
        run = 0;
      end
    end
  end
  initial begin
    int acc;
    int waited;
    int cnt;
    for (int i = 0; i < 24; i++) begin
      int cy;
      cy = i + 1;
      tbl[i].v = i < 2;
      tbl[i].s = i == 1;
      tbl[i].abcd = cy <= 10 ? 4'h6 : cy == 11 ? 4'h0 : cy <= 21 ? 4'hb : 4'h0;
      tbl[i].busy = cy <= 22;
      tbl[i].done = cy == 10 || cy == 21;
      tbl[i].ready = !(cy >= 2 && cy <= 11);
    end
    #12;
    check("reset abcd", 32'({a, b, c, d}), 32'h0);
    check("reset busy", 32'(tx_busy), 32'h0);
    check("reset done", 32'(tx_done), 32'h0);
    check("reset ready", 32'(req_ready), 32'h1);
    // single CT1 then pended CT2
    do_reset();
    for (int i = 0; i < 24; i++) begin
      req_valid = tbl[i].v;
      req_sel = tbl[i].s;
      @(negedge clk);
      check($sformatf("vec%0d abcd", i), 32'({a, b, c, d}), 32'(tbl[i].abcd));
      check($sformatf("vec%0d busy", i), 32'(tx_busy), 32'(tbl[i].busy));
      check($sformatf("vec%0d done", i), 32'(tx_done), 32'(tbl[i].done));
      check($sformatf("vec%0d ready", i), 32'(req_ready), 32'(tbl[i].ready));
    end
    // third request held while pending is full
    do_reset();
    acc = -1;
    for (int i = 0; i < 36; i++) begin
      req_valid = (i < 2) || (acc < 0);
      req_sel = i == 1;
      if (i >= 2 && acc < 0 && req_ready) acc = i;
      @(negedge clk);
      log_bus[i + 1] = {a, b, c, d};
    end
    req_valid = 1'b0;
    check("held req accept edge", acc, 12);
    check("held cy12", 32'(log_bus[12]), 32'hb);
    check("held cy22", 32'(log_bus[22]), 32'h0);
    cnt = 0;
    for (int cy = 23; cy <= 32; cy++) if (log_bus[cy] == 4'h6) cnt++;
    check("held CT1 cycles 23-32", cnt, 10);
    check("held cy33", 32'(log_bus[33]), 32'h0);
    // gap 0 back-to-back CT2 then CT1
    do_reset();
    for (int i = 0; i < 24; i++) begin
      req0_valid = i < 2;
      req0_sel = i == 0;
      @(negedge clk);
      log_bus[i + 1] = {a0, b0, c0, d0};
      log_busy[i + 1] = busy0;
      log_done[i + 1] = done0;
    end
    req0_valid = 1'b0;
    for (int cy = 1; cy <= 21; cy++)
      check($sformatf("gap0 cy%0d", cy), 32'(log_bus[cy]), cy <= 10 ? 32'hb : cy <= 20 ? 32'h6 : 32'h0);
    cnt = 0;
    for (int cy = 1; cy <= 20; cy++) if (!log_busy[cy]) cnt++;
    check("gap0 busy drops", cnt, 0);
    cnt = 0;
    for (int cy = 1; cy <= 24; cy++) if (log_done[cy]) cnt++;
    check("gap0 done pulses", cnt, 2);
    check("gap0 done cy10", 32'(log_done[10]), 32'h1);
    check("gap0 done cy20", 32'(log_done[20]), 32'h1);
    // reset mid-token with CT2 pending
    do_reset();
    for (int i = 0; i < 5; i++) begin
      req_valid = i < 2;
      req_sel = i == 1;
      @(negedge clk);
    end
    req_valid = 1'b0;
    check("pre-abort ready", 32'(req_ready), 32'h0);
    #1 rst_n = 1'b0;
    #1;
    check("abort abcd", 32'({a, b, c, d}), 32'h0);
    check("abort busy", 32'(tx_busy), 32'h0);
    check("abort ready", 32'(req_ready), 32'h1);
    check("abort done", 32'(tx_done), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if ({a, b, c, d} != 4'h0 || tx_busy || tx_done) cnt++;
    end
    check("no token after abort", cnt, 0);
    // random stream against reference monitor
    do_reset();
    mon_en = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      req_sel = 1'($urandom_range(0, 1));
      req_valid = 1'b1;
      waited = 0;
      while (!req_ready && waited < 100) begin
        @(negedge clk);
        waited++;
      end
      if (waited >= 100) begin
        check("random accept timeout", waited, 0);
        req_valid = 1'b0;
        break;
      end
      q.push_back(req_sel ? 4'hb : 4'h6);
      @(negedge clk);
      req_valid = 1'b0;
    end
    repeat (40) @(negedge clk);
    mon_en = 1'b0;
    check("random tokens out", tokens, 1000);
    check("random queue drained", 32'(q.size()), 32'h0);
    check("random run closed", run, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
